// File: rtl/chain_ctrl_pkg.sv
// chain_ctrl_pkg: shared state encoding and default widths for the counter-chain run controller.
package chain_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;
  localparam int DEF_CLR_CYCLES   = 4;
  localparam int DEF_TARGET_WRAPS = 1;
  localparam int DEF_WRAP_W       = 8;
  localparam int DEF_CYC_W        = 32;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter that sticks at all-ones and flags any increment lost to saturation.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_q,
  output logic         o_sat
);
  logic [W-1:0] r_q;
  logic         r_sat;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q   <= '0;
      r_sat <= 1'b0;
    end else if (i_clr) begin
      r_q   <= '0;
      r_sat <= 1'b0;
    end else if (i_inc) begin
      r_q   <= &r_q ? r_q : r_q + W'(1);
      r_sat <= r_sat | (&r_q);
    end
  end
  assign o_q   = r_q;
  assign o_sat = r_sat;
endmodule

// File: rtl/chain_run_ctrl.sv
// chain_run_ctrl: clears the cascaded counter chain, runs it for a target number of final-stage wraps,
// and measures the exact number of enabled cycles of the run.
module chain_run_ctrl
  import chain_ctrl_pkg::*;
#(
  parameter int CLR_CYCLES   = DEF_CLR_CYCLES,
  parameter int TARGET_WRAPS = DEF_TARGET_WRAPS,
  parameter int WRAP_W       = DEF_WRAP_W,
  parameter int CYC_W        = DEF_CYC_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              pause,
  input  logic              first_tc,
  input  logic              final_tc,
  output logic              chain_reset,
  output logic              chain_enable,
  output logic              busy,
  output logic              done,
  output logic              heartbeat,
  output logic [WRAP_W-1:0] wrap_cnt,
  output logic [CYC_W-1:0]  run_cycles,
  output logic              cyc_ovf
);
  localparam int CLR_W = CLR_CYCLES > 1 ? $clog2(CLR_CYCLES) : 1;
  state_t            r_state;
  logic [CLR_W-1:0]  r_clr_cnt;
  logic [WRAP_W-1:0] r_wrap_cnt;
  logic              r_chain_reset, r_chain_enable, r_heartbeat;
  logic              w_clr, w_inc, w_last;
  assign w_clr  = start && !abort && (r_state == IDLE || r_state == DONE);
  assign w_inc  = r_chain_enable && !abort;
  // enable is only ever high in RUN, so it alone marks a counted cycle
  assign w_last = r_chain_enable && final_tc && r_wrap_cnt == WRAP_W'(TARGET_WRAPS - 1);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= IDLE;
      r_chain_reset  <= 1'b1;
      r_chain_enable <= 1'b0;
      r_heartbeat    <= 1'b0;
      r_wrap_cnt     <= '0;
      r_clr_cnt      <= '0;
    end else if (abort) begin
      r_state        <= IDLE;
      r_chain_reset  <= 1'b1;
      r_chain_enable <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          r_chain_reset  <= start;
          r_chain_enable <= 1'b0;
          if (start) begin
            r_state     <= CLEAR;
            r_clr_cnt   <= '0;
            r_wrap_cnt  <= '0;
            r_heartbeat <= 1'b0;
          end
        end
        CLEAR: begin
          r_clr_cnt <= r_clr_cnt + CLR_W'(1);
          if (r_clr_cnt == CLR_W'(CLR_CYCLES - 1)) begin
            r_state        <= RUN;
            r_chain_reset  <= 1'b0;
            r_chain_enable <= !pause;
          end
        end
        RUN: begin
          if (r_chain_enable) begin
            r_heartbeat <= r_heartbeat ^ first_tc;
            r_wrap_cnt  <= final_tc ? r_wrap_cnt + WRAP_W'(1) : r_wrap_cnt;
          end
          r_chain_enable <= !pause && !w_last;
          if (w_last) r_state <= DONE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  sat_counter #(.W(CYC_W)) u_cyc (
    .clk  (clk),
    .rst  (reset),
    .i_clr(w_clr),
    .i_inc(w_inc),
    .o_q  (run_cycles),
    .o_sat(cyc_ovf)
  );
  assign chain_reset  = r_chain_reset;
  assign chain_enable = r_chain_enable;
  assign busy         = r_state == CLEAR || r_state == RUN;
  assign done         = r_state == DONE;
  assign heartbeat    = r_heartbeat;
  assign wrap_cnt     = r_wrap_cnt;
endmodule

// File: tb/tb_chain_run_ctrl.sv
// tb_chain_run_ctrl: three controllers (1 wrap, 3 wraps, 4-bit cycle counter) each driving a 4-bit chain model,
// fed identical random stimulus and checked against an enabled-cycle counting model.
module tb_chain_run_ctrl;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, abort = 1'b0, pause = 1'b0, ftc_drv = 1'b0, junk = 1'b0;
  logic [2:0] cr_v, ce_v, bz_v, dn_v, hb_v, ov_v;
  logic [2:0][31:0] rc_v;
  logic [2:0][7:0] wc_v;
  int n_chk = 0, n_fail = 0;
  int n_en[3];
  bit exp_en[3], fin[3], hb_m[3];
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : u
    localparam int TW = (g == 1) ? 3 : 1;
    localparam int CW = (g == 2) ? 4 : 32;
    logic cr, ce, bz, dn, hb, ov, ltc;
    logic [7:0] wc;
    logic [CW-1:0] rc;
    logic [3:0] cnt;
    // single-stage chain; spurious tc while disabled must be ignored by the controller
    always @(posedge clk) cnt <= cr ? 4'd0 : cnt + {3'd0, ce};
    assign ltc = ce ? (cnt == 4'hf) : junk;
    chain_run_ctrl #(.CLR_CYCLES(4), .TARGET_WRAPS(TW), .WRAP_W(8), .CYC_W(CW)) dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort), .pause(pause),
      .first_tc(ftc_drv), .final_tc(ltc), .chain_reset(cr), .chain_enable(ce), .busy(bz),
      .done(dn), .heartbeat(hb), .wrap_cnt(wc), .run_cycles(rc), .cyc_ovf(ov));
    assign cr_v[g] = cr;
    assign ce_v[g] = ce;
    assign bz_v[g] = bz;
    assign dn_v[g] = dn;
    assign hb_v[g] = hb;
    assign ov_v[g] = ov;
    assign wc_v[g] = wc;
    assign rc_v[g] = 32'(rc);
  end
  function automatic int tgt(int g);
    return g == 1 ? 3 : 1;
  endfunction
  function automatic longint mx(int g);
    return g == 2 ? 64'd15 : 64'hffff_ffff;
  endfunction
  task automatic do_run(input int pmode, input bit ab_term, input string tag);
    int it;
    bit ab, p;
    longint e_rc;
    start = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      n_chk++;
      if (cr_v !== 3'b111 || ce_v !== 3'b000 || bz_v !== 3'b111 || dn_v !== 3'b000) begin
        n_fail++;
        $display("FAIL %s clear[%0d]: cr=%b ce=%b busy=%b done=%b, want 111 000 111 000", tag, k, cr_v, ce_v, bz_v, dn_v);
      end
      if (k == 0) begin
        n_chk++;
        if (rc_v !== '0 || wc_v !== '0 || hb_v !== 3'b000 || ov_v !== 3'b000) begin
          n_fail++;
          $display("FAIL %s counters_cleared: rc=%h wc=%h hb=%b ov=%b, want all zero", tag, rc_v, wc_v, hb_v, ov_v);
        end
      end
      start = 1'($urandom_range(0, 1));
      junk = 1'($urandom);
      @(negedge clk);
    end
    for (int g = 0; g < 3; g++) begin
      n_en[g] = 0;
      exp_en[g] = 1'b1;
      fin[g] = 1'b0;
      hb_m[g] = 1'b0;
    end
    ab = 1'b0;
    for (it = 0; it < 1000 && !(fin[0] && fin[1] && fin[2]); it++) begin
      for (int g = 0; g < 3; g++) begin
        n_chk++;
        if ({ce_v[g], dn_v[g], bz_v[g], cr_v[g]} !== {exp_en[g], fin[g], !fin[g], 1'b0}) begin
          n_fail++;
          $display("FAIL %s cyc%0d u%0d: ce/done/busy/cr=%b%b%b%b, want %b%b%b0", tag, it, g,
                   ce_v[g], dn_v[g], bz_v[g], cr_v[g], exp_en[g], fin[g], !fin[g]);
        end
      end
      ftc_drv = 1'($urandom);
      junk = 1'($urandom);
      p = pmode == 1 ? ($urandom_range(0, 3) == 0) : (pmode == 2 ? (it >= 5 && it < 15) : 1'b0);
      for (int g = 0; g < 3; g++)
        if (ab_term && exp_en[g] && n_en[g] + 1 == 16 * tgt(g)) ab = 1'b1;
      if (!ab)
        for (int g = 0; g < 3; g++) begin
          if (exp_en[g]) begin
            n_en[g]++;
            hb_m[g] ^= ftc_drv;
          end
          if (!fin[g]) begin
            if (exp_en[g] && n_en[g] == 16 * tgt(g)) begin
              fin[g] = 1'b1;
              exp_en[g] = 1'b0;
            end else exp_en[g] = !p;
          end
        end
      abort = ab;
      pause = p;
      start = (fin[0] || fin[1] || fin[2]) ? 1'b0 : 1'($urandom);
      @(negedge clk);
      if (ab) break;
    end
    abort = 1'b0;
    start = 1'b0;
    pause = 1'b0;
    n_chk++;
    if (ab) begin
      if (cr_v !== 3'b111 || ce_v !== 3'b000 || bz_v !== 3'b000 || dn_v !== 3'b000) begin
        n_fail++;
        $display("FAIL %s abort_idle: cr=%b ce=%b busy=%b done=%b, want 111 000 000 000", tag, cr_v, ce_v, bz_v, dn_v);
      end
    end else if (!(fin[0] && fin[1] && fin[2]) || ce_v !== 3'b000 || dn_v !== 3'b111 || bz_v !== 3'b000 || cr_v !== 3'b000) begin
      n_fail++;
      $display("FAIL %s done_state: ce=%b done=%b busy=%b cr=%b fin=%b%b%b, want 000 111 000 000 all finished", tag,
               ce_v, dn_v, bz_v, cr_v, fin[2], fin[1], fin[0]);
    end
    for (int g = 0; g < 3; g++) begin
      e_rc = n_en[g] > mx(g) ? mx(g) : longint'(n_en[g]);
      n_chk++;
      if (rc_v[g] !== 32'(e_rc) || wc_v[g] !== 8'(n_en[g] / 16) || hb_v[g] !== hb_m[g]) begin
        n_fail++;
        $display("FAIL %s counters u%0d: run_cycles=%0d wrap=%0d hb=%b, want %0d %0d %b", tag, g,
                 rc_v[g], wc_v[g], hb_v[g], e_rc, n_en[g] / 16, hb_m[g]);
      end
      if (n_en[g] != mx(g)) begin
        n_chk++;
        if (ov_v[g] !== (n_en[g] > mx(g))) begin
          n_fail++;
          $display("FAIL %s cyc_ovf u%0d: got %b, want %b", tag, g, ov_v[g], n_en[g] > mx(g));
        end
      end
    end
    if (ab) begin
      @(negedge clk);
      n_chk++;
      if (cr_v !== 3'b000 || bz_v !== 3'b000 || dn_v !== 3'b000) begin
        n_fail++;
        $display("FAIL %s abort_pulse_end: cr=%b busy=%b done=%b, want 000 000 000", tag, cr_v, bz_v, dn_v);
      end
    end
  endtask
  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_chk++;
    if (cr_v !== 3'b111 || ce_v !== 3'b000 || bz_v !== 3'b000 || dn_v !== 3'b000 || hb_v !== 3'b000 ||
        ov_v !== 3'b000 || rc_v !== '0 || wc_v !== '0) begin
      n_fail++;
      $display("FAIL reset_values: cr=%b ce=%b busy=%b done=%b hb=%b ov=%b rc=%h wc=%h, want cr=111 rest 0",
               cr_v, ce_v, bz_v, dn_v, hb_v, ov_v, rc_v, wc_v);
    end
    reset = 1'b0;
    @(negedge clk);
    n_chk++;
    if (cr_v !== 3'b000 || bz_v !== 3'b000 || ce_v !== 3'b000) begin
      n_fail++;
      $display("FAIL idle_after_reset: cr=%b busy=%b ce=%b, want 000 000 000", cr_v, bz_v, ce_v);
    end
  endtask
  task automatic test_basic_run();
    do_run(0, 1'b0, "basic");
  endtask
  task automatic test_back_to_back();
    do_run(1, 1'b0, "b2b_a");
    do_run(1, 1'b0, "b2b_b");
  endtask
  task automatic test_pause_window();
    do_run(2, 1'b0, "pause10");
  endtask
  task automatic test_abort_terminal();
    do_run(1, 1'b1, "abort_term");
    do_run(0, 1'b0, "after_abort");
  endtask
  task automatic test_async_reset();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_chk++;
    if (bz_v !== 3'b111 || ce_v !== 3'b111 || dn_v !== 3'b000 || cr_v !== 3'b000) begin
      n_fail++;
      $display("FAIL start_in_run: busy=%b ce=%b done=%b cr=%b, want 111 111 000 000", bz_v, ce_v, dn_v, cr_v);
    end
    #2 reset = 1'b1;
    #1;
    n_chk++;
    if (cr_v !== 3'b111 || ce_v !== 3'b000 || bz_v !== 3'b000 || dn_v !== 3'b000 || rc_v !== '0 || wc_v !== '0 ||
        hb_v !== 3'b000 || ov_v !== 3'b000) begin
      n_fail++;
      $display("FAIL async_reset: cr=%b ce=%b busy=%b done=%b rc=%h wc=%h, want cr=111 rest 0", cr_v, ce_v, bz_v, dn_v, rc_v, wc_v);
    end
    @(negedge clk);
    n_chk++;
    if (cr_v !== 3'b111 || bz_v !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_held: cr=%b busy=%b, want 111 000", cr_v, bz_v);
    end
    reset = 1'b0;
    @(negedge clk);
    n_chk++;
    if (cr_v !== 3'b000 || bz_v !== 3'b000 || ce_v !== 3'b000) begin
      n_fail++;
      $display("FAIL post_reset_idle: cr=%b busy=%b ce=%b, want 000 000 000", cr_v, bz_v, ce_v);
    end
  endtask
  initial begin
    test_reset();
    test_basic_run();
    test_back_to_back();
    test_pause_window();
    test_abort_terminal();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
